// File: rtl/simon_engine.sv
// SIMON block cipher engine with an on-chip key expander.
// N=16 gives SIMON32/64 (32 rounds, z0); N=32 gives SIMON64/128 (44 rounds, z3).
// One round per cycle. The expanded key schedule lives in a T x N register file.
module simon_engine #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_load,
  input  logic [4*N-1:0] key_in,
  output logic           key_ready,
  input  logic           start,
  input  logic           decrypt,
  input  logic [2*N-1:0] block_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] block_out,
  output logic           err
);

  localparam int unsigned T    = (N == 16) ? 32 : 44;
  localparam int unsigned IdxW = $clog2(T);

  // z sequences written with z[0] as the leftmost character.
  localparam logic [61:0] Z0   = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z3   = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] ZSeq = (N == 16) ? Z0 : Z3;

  localparam logic [IdxW-1:0] LastExp = IdxW'(T - 5);
  localparam logic [IdxW-1:0] LastRnd = IdxW'(T - 1);

  if (N != 16 && N != 32) begin : g_bad_width
    $error("simon_engine: N must be 16 or 32");
  end

  typedef enum logic [1:0] {StIdle, StExpand, StReady, StRun} state_e;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] rf(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    x_q, x_d, y_q, y_d;
  logic            dec_q, dec_d;
  logic [2*N-1:0]  out_q, out_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            kready_q, kready_d;
  logic            load_we, exp_we;

  logic [N-1:0]    key_q [T];

  // Key expansion datapath: produces k[cnt+4] from k[cnt], k[cnt+1], k[cnt+3].
  logic [N-1:0]    k_i, k_i1, k_i3, tmp, new_key;
  logic [5:0]      z_idx;
  logic            z_bit;

  assign k_i     = key_q[cnt_q];
  assign k_i1    = key_q[cnt_q + IdxW'(1)];
  assign k_i3    = key_q[cnt_q + IdxW'(3)];
  assign tmp     = ror(k_i3, 3) ^ k_i1;
  assign z_idx   = 6'd61 - 6'(cnt_q);
  assign z_bit   = ZSeq[z_idx];
  assign new_key = ~k_i ^ tmp ^ ror(tmp, 1) ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);

  // Round datapath: decrypt walks the schedule backwards.
  logic [IdxW-1:0] kidx;
  logic [N-1:0]    rk, rnd_x, rnd_y;

  assign kidx  = dec_q ? (LastRnd - cnt_q) : cnt_q;
  assign rk    = key_q[kidx];
  assign rnd_x = dec_q ? y_q : (y_q ^ rf(x_q) ^ rk);
  assign rnd_y = dec_q ? (x_q ^ rf(y_q) ^ rk) : x_q;

  // Next-state logic, datapath register updates and request arbitration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dec_d    = dec_q;
    out_d    = out_q;
    done_d   = 1'b0;
    kready_d = kready_q;
    load_we  = 1'b0;
    exp_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_load) begin
          load_we  = 1'b1;
          kready_d = 1'b0;
          cnt_d    = '0;
          state_d  = StExpand;
        end
      end
      StExpand: begin
        exp_we = 1'b1;
        if (cnt_q == LastExp) begin
          cnt_d    = '0;
          kready_d = 1'b1;
          state_d  = StReady;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      StReady: begin
        if (key_load) begin
          load_we  = 1'b1;
          kready_d = 1'b0;
          cnt_d    = '0;
          state_d  = StExpand;
        end else if (start) begin
          x_d     = block_in[2*N-1:N];
          y_d     = block_in[N-1:0];
          dec_d   = decrypt;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d = rnd_x;
        y_d = rnd_y;
        if (cnt_q == LastRnd) begin
          out_d   = {rnd_x, rnd_y};
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // key_load wins over start in READY, so start is only honoured alone in READY.
    err_d = (start && !(state_q == StReady && !key_load)) ||
            (key_load && (state_q == StExpand || state_q == StRun));
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dec_q    <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dec_q    <= dec_d;
      out_q    <= out_d;
      done_q   <= done_d;
      err_q    <= err_d;
      kready_q <= kready_d;
    end
  end

  // Key register file: seed words on load, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (rst && load_we) begin
      for (int k = 0; k < 4; k++) begin
        key_q[k] <= key_in[k*N +: N];
      end
    end else if (rst && exp_we) begin
      key_q[cnt_q + IdxW'(4)] <= new_key;
    end
  end

  assign busy      = (state_q == StExpand) || (state_q == StRun);
  assign done      = done_q;
  assign err       = err_q;
  assign key_ready = kready_q;
  assign block_out = out_q;

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 SHALL have parameter N, default 32, meaning word size in bits; legal values 16 (SIMON32/64) and 32 (SIMON64/128); key is always 4 words (m=4).
REQ-002 SHALL derive T = 32 rounds with z0 sequence when N=16, and T = 44 rounds with z3 sequence when N=32; any other N is an elaboration error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 key_load  input  1  one-cycle request to load and expand a new key.
REQ-006 key_in  input  4N  key {k3,k2,k1,k0}; k0 in LSBs is round key 0.
REQ-007 key_ready  output  1  high when a fully expanded key schedule is stored.
REQ-008 start  input  1  one-cycle request to process block_in.
REQ-009 decrypt  input  1  sampled with start: 0 = encrypt, 1 = decrypt.
REQ-010 block_in  input  2N  {x,y}; x in MSBs.
REQ-011 busy  output  1  high while expanding or running rounds.
REQ-012 done  output  1  one-cycle pulse; block_out valid.
REQ-013 block_out  output  2N  result {x,y}; held until the next done.
REQ-014 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 SHALL implement states IDLE, EXPAND, READY, RUN.
REQ-016 Round function SHALL be f(x) = (ROL1 x & ROL8 x) ^ ROL2 x, with all arithmetic mod 2^N.
- Encrypt round: x' = y ^ f(x) ^ k[i], y' = x; i = 0..T-1.
- Decrypt round: y' = x ^ f(y) ^ k[i], x' = y; i = T-1..0.
REQ-017 Key schedule SHALL compute, for i = 0..T-5:
- tmp = ROR3 k[i+3] ^ k[i+1]
- k[i+4] = ~k[i] ^ tmp ^ ROR1 tmp ^ z[i mod 62] ^ 3
REQ-018 Expanded key schedule SHALL be stored in a T x N register file.
REQ-019 key_load in IDLE or READY:
- k0..k3 written on the sampling edge; key_ready cleared; state becomes EXPAND.
- EXPAND writes one key per cycle for exactly T-4 cycles, then enters READY with key_ready=1.
REQ-020 start in READY SHALL:
- register block_in and decrypt on the sampling edge; enter RUN.
- apply one round per cycle for T cycles.
- on the T-th following edge, register block_out, pulse done, and return to READY.
REQ-021 Latency from the start-sampling edge to done high SHALL be T edges; block throughput SHALL be one block per T+1 cycles.
REQ-022 busy SHALL equal (state==EXPAND || state==RUN).
REQ-023 Rejected requests SHALL pulse err one cycle later and change no other state:
- start in IDLE, EXPAND or RUN.
- key_load in EXPAND or RUN.
REQ-024 Simultaneous key_load and start in READY: key_load SHALL win, start is rejected, err pulses.
REQ-025 start asserted in the same cycle as done SHALL be accepted, since state is READY on the next edge; back-to-back blocks SHALL have no bubble beyond REQ-021.
REQ-026 block_in, decrypt and key_in SHALL only be sampled on accepting edges; changes mid-operation SHALL have no effect.

Reset
REQ-027 rst=0 at a rising edge SHALL force:
- state IDLE; busy=0, done=0, err=0, key_ready=0.
- block_out = 0.
- round counter = 0.
- key file contents are don't-care.
REQ-028 Reset asserted mid-EXPAND or mid-RUN SHALL abort at that edge: no done pulse, key_ready=0, and a new key_load is required before start.

Verification
REQ-029 N=16, key_in=0x1918_1110_0908_0100, encrypt block_in=0x6565_6877 -> done 32 edges after start, block_out=0xC69B_E9BB.
REQ-030 N=32, key_in=0x1B1A1918_13121110_0B0A0908_03020100, encrypt block_in=0x656B696C_20646E75 -> done 44 edges after start, block_out=0x44C8FC20_B9DFA07A.
REQ-031 Same key, decrypt of each ciphertext in REQ-029/REQ-030 -> block_out equals the original plaintext; encrypt then decrypt back-to-back with start in the done cycle -> no gap and both results correct.
REQ-032 start after reset before any key_load -> err pulses, busy stays 0, done never pulses; key_load during RUN -> err pulses and the running block completes correctly.
REQ-033 Simultaneous key_load and start in READY -> err pulses, EXPAND entered (28 or 40 cycles), key_ready=1 afterwards.
REQ-034 rst=0 at round 10 of RUN -> next cycle busy=0, key_ready=0, block_out=0, no done; start then -> err.
